// File: rtl/effect_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : effect_sequencer
//  Purpose  : Steps through a small program of 4-bit effect opcodes and drives
//             the color, sound (valid/ready), wave/jaw pulse and fog outputs.
//             Each effect is held for DWELL cycles.
//  Revision : 1.0  initial release
// ============================================================================
module effect_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [3:0]    prog_data,
  output logic          snd_valid,
  output logic [1:0]    snd_code,
  input  logic          snd_ready,
  output logic [1:0]    color,
  output logic          wave,
  output logic          jaw,
  output logic          fog_on,
  output logic          busy,
  output logic [AW-1:0] pc
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_EXEC     = 3'd2;
  localparam logic [2:0] S_WAIT_SND = 3'd3;
  localparam logic [2:0] S_DWELL    = 3'd4;

  localparam logic [CW-1:0] C_DWELL = CW'(DWELL);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stop_pend_q, stop_pend_d;
  logic [1:0]    color_q, color_d;
  logic          snd_valid_q, snd_valid_d;
  logic [1:0]    snd_code_q, snd_code_d;
  logic          wave_q, wave_d;
  logic          jaw_q, jaw_d;
  logic          fog_q, fog_d;

  // A stop arriving in the same cycle as a halt point still counts.
  logic w_stop;
  logic w_dwell_last;
  logic w_reset_op;
  logic w_sound_op;

  assign w_stop       = stop_pend_q | stop;
  assign w_dwell_last = (cnt_q == C_ONE);
  assign w_reset_op   = (op_q == 4'b0001);
  assign w_sound_op   = (op_q[3:2] == 2'b10) && (op_q[1:0] != 2'b11);

  // Program store: writable only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_FETCH;
      S_FETCH:    state_d = S_EXEC;
      S_EXEC: begin
        if (w_reset_op)      state_d = w_stop ? S_IDLE : S_FETCH;
        else if (w_sound_op) state_d = S_WAIT_SND;
        else                 state_d = S_DWELL;
      end
      S_WAIT_SND: if (snd_valid_q && snd_ready) state_d = S_DWELL;
      S_DWELL:    if (w_dwell_last) state_d = w_stop ? S_IDLE : S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  // FSM outputs derived directly from state.
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Datapath next values: opcode latch, pc, dwell counter and actuator regs.
  always_comb begin
    op_d        = op_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    color_d     = color_q;
    snd_valid_d = snd_valid_q;
    snd_code_d  = snd_code_q;
    wave_d      = 1'b0;
    jaw_d       = 1'b0;
    fog_d       = fog_q;
    if (state_q != S_IDLE && stop) stop_pend_d = 1'b1;
    case (state_q)
      S_FETCH: op_d = mem_q[pc_q];
      S_EXEC: begin
        cnt_d = C_DWELL;
        case (op_q[3:2])
          2'b00: begin
            if (op_q[1:0] == 2'b01) begin
              pc_d    = '0;
              color_d = 2'b00;
              fog_d   = 1'b0;
              if (w_stop) stop_pend_d = 1'b0;
            end
          end
          2'b01: color_d = (op_q[1:0] == 2'b11) ? 2'b00 : op_q[1:0] + 2'b01;
          2'b10: begin
            if (op_q[1:0] != 2'b11) begin
              snd_valid_d = 1'b1;
              snd_code_d  = op_q[1:0];
            end
          end
          default: begin
            case (op_q[1:0])
              2'b00:   wave_d = 1'b1;
              2'b01:   jaw_d  = 1'b1;
              2'b10:   fog_d  = 1'b1;
              default: ;
            endcase
          end
        endcase
      end
      S_WAIT_SND: begin
        cnt_d = C_DWELL;
        if (snd_ready) snd_valid_d = 1'b0;
      end
      S_DWELL: begin
        cnt_d = cnt_q - C_ONE;
        if (w_dwell_last) begin
          pc_d  = pc_q + AW'(1);
          fog_d = 1'b0;
          if (w_stop) stop_pend_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= 4'b0000;
      pc_q        <= '0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      color_q     <= 2'b00;
      snd_valid_q <= 1'b0;
      snd_code_q  <= 2'b00;
      wave_q      <= 1'b0;
      jaw_q       <= 1'b0;
      fog_q       <= 1'b0;
    end else begin
      op_q        <= op_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      color_q     <= color_d;
      snd_valid_q <= snd_valid_d;
      snd_code_q  <= snd_code_d;
      wave_q      <= wave_d;
      jaw_q       <= jaw_d;
      fog_q       <= fog_d;
    end
  end

  assign snd_valid = snd_valid_q;
  assign snd_code  = snd_code_q;
  assign color     = color_q;
  assign wave      = wave_q;
  assign jaw       = jaw_q;
  assign fog_on    = fog_q;
  assign pc        = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_effect_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_effect_sequencer
//  Purpose  : Self-checking bench for effect_sequencer. An effect-level model
//             predicts each opcode's cycle-by-cycle outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_effect_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int DWELL = 4;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [3:0]    prog_data;
  logic          snd_valid;
  logic [1:0]    snd_code;
  logic          snd_ready;
  logic [1:0]    color;
  logic          wave;
  logic          jaw;
  logic          fog_on;
  logic          busy;
  logic [AW-1:0] pc;

  effect_sequencer #(.DEPTH(DEPTH), .AW(AW), .DWELL(DWELL), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .snd_valid(snd_valid), .snd_code(snd_code), .snd_ready(snd_ready),
    .color(color), .wave(wave), .jaw(jaw), .fog_on(fog_on),
    .busy(busy), .pc(pc)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [3:0] m_mem [DEPTH];
  int         m_pc;
  int         m_color;
  bit         m_stop;
  bit         halted;
  int         nw;
  int         sa;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] obs_v();
    return 32'({busy, pc, color, wave, jaw, fog_on, snd_valid});
  endfunction

  function automatic logic [31:0] exp_v(input bit b, input int p, input int c,
                                        input bit w, input bit j, input bit f, input bit v);
    logic [1:0] pp;
    logic [1:0] cc;
    pp = p[1:0];
    cc = c[1:0];
    return 32'({b, pp, cc, w, j, f, v});
  endfunction

  task automatic write(input int a, input int d, input bit with_start);
    prog_we   = 1'b1;
    prog_addr = a[AW-1:0];
    prog_data = d[3:0];
    start     = with_start;
    step();
    prog_we = 1'b0;
    start   = 1'b0;
    m_mem[a] = d[3:0];
  endtask

  task automatic kick();
    check("idle_before_start", obs_v(), exp_v(0, m_pc, m_color, 0, 0, 0, 0));
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_pc = 0; m_color = 0; m_stop = 0;
  endtask

  // Entered in the FETCH cycle; leaves in the next FETCH or in IDLE.
  // stop_at: -1 none, 0 during FETCH, 1 during the second dwell cycle.
  task automatic run_effect(input int ready_wait, input int stop_at, output bit hlt);
    logic [3:0] op;
    op  = m_mem[m_pc];
    hlt = 1'b0;
    if (stop_at == 0) begin stop = 1'b1; m_stop = 1'b1; end
    prog_we   = 1'b1;                         // must be ignored while busy
    prog_addr = AW'($urandom_range(0, DEPTH-1));
    prog_data = 4'($urandom_range(0, 15));
    check("fetch", obs_v(), exp_v(1, m_pc, m_color, 0, 0, 0, 0));
    step();
    stop = 1'b0; prog_we = 1'b0;
    check("exec", obs_v(), exp_v(1, m_pc, m_color, 0, 0, 0, 0));
    step();
    if (op == 4'b0001) begin
      m_pc = 0; m_color = 0;
      if (m_stop) begin
        m_stop = 0; hlt = 1'b1;
        check("reset_op_halt", obs_v(), exp_v(0, 0, 0, 0, 0, 0, 0));
      end else begin
        check("reset_op_refetch", obs_v(), exp_v(1, 0, 0, 0, 0, 0, 0));
      end
      return;
    end
    if (op[3:2] == 2'b10 && op[1:0] != 2'b11) begin
      for (int i = 0; i <= ready_wait; i++) begin
        snd_ready = (i == ready_wait);
        check("snd_wait", obs_v(), exp_v(1, m_pc, m_color, 0, 0, 0, 1));
        check("snd_code", 32'(snd_code), 32'(op[1:0]));
        step();
      end
    end
    if (op[3:2] == 2'b01) m_color = (op[1:0] == 2'b11) ? 0 : op[1:0] + 1;
    for (int d = 0; d < DWELL; d++) begin
      snd_ready = 1'($urandom_range(0, 1));
      if (stop_at == 1 && d == 1) begin stop = 1'b1; m_stop = 1'b1; end
      check("dwell", obs_v(), exp_v(1, m_pc, m_color, op == 4'b1100 && d == 0,
                                    op == 4'b1101 && d == 0, op == 4'b1110, 0));
      step();
      stop = 1'b0;
    end
    m_pc = (m_pc + 1) % DEPTH;
    if (m_stop) begin
      m_stop = 0; hlt = 1'b1;
      check("halt", obs_v(), exp_v(0, m_pc, m_color, 0, 0, 0, 0));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = 4'h0; snd_ready = 1'b0;
    m_pc = 0; m_color = 0; m_stop = 0;
    repeat (3) step();
    check("reset_outputs", obs_v(), exp_v(0, 0, 0, 0, 0, 0, 0));
    check("reset_snd_code", 32'(snd_code), 32'd0);
    rst = 1'b0;
    step();

    // Green, scream, jaw, RESET; the last write coincides with start.
    write(0, 4'b0100, 0);
    write(1, 4'b1000, 0);
    write(2, 4'b1101, 0);
    write(3, 4'b0001, 1);
    for (int e = 0; e < 8; e++) run_effect(0, -1, halted);
    run_effect(0, -1, halted);
    run_effect(0, 1, halted);                 // stop during entry 1 dwell
    check("halted_after_stop", 32'(halted), 32'd1);
    repeat (3) begin
      step();
      check("idle_hold", obs_v(), exp_v(0, m_pc, m_color, 0, 0, 0, 0));
    end
    write(3, 4'b0110, 0);                     // orange on entry 3
    kick();
    run_effect(0, -1, halted);
    run_effect(0, -1, halted);
    check("orange_color", 32'(color), 32'd3);
    run_effect(0, 0, halted);

    // Long sound handshake followed by fog dwells.
    do_reset();
    write(0, 4'b1010, 0);
    write(1, 4'b1110, 0);
    write(2, 4'b1110, 0);
    write(3, 4'b1110, 0);
    kick();
    run_effect(7, -1, halted);
    for (int e = 0; e < 3; e++) run_effect(0, -1, halted);
    run_effect($urandom_range(0, 5), 0, halted);

    // Asynchronous reset while a sound request is outstanding.
    do_reset();
    write(0, 4'b0110, 0);
    write(1, 4'b1000, 0);
    write(2, 4'b1110, 0);
    write(3, 4'b0001, 0);
    snd_ready = 1'b0;
    kick();
    run_effect(0, -1, halted);
    check("fetch", obs_v(), exp_v(1, 1, 3, 0, 0, 0, 0));
    step();
    step();
    check("wait_snd_pending", obs_v(), exp_v(1, 1, 3, 0, 0, 0, 1));
    rst = 1'b1;
    #1;
    check("async_rst_outputs", obs_v(), exp_v(0, 0, 0, 0, 0, 0, 0));
    #2;
    rst = 1'b0;
    m_pc = 0; m_color = 0; m_stop = 0;
    step();
    kick();
    run_effect(2, -1, halted);
    run_effect(1, 0, halted);

    // Randomized programs, handshake delays and stop points.
    for (int it = 0; it < 30; it++) begin
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) write($urandom_range(0, DEPTH-1), $urandom_range(0, 15), 0);
      kick();
      halted = 1'b0;
      for (int e = 0; e < 12 && !halted; e++) begin
        if (e == 11)                        sa = 0;
        else if ($urandom_range(0, 3) == 0) sa = $urandom_range(0, 1);
        else                                sa = -1;
        run_effect($urandom_range(0, 5), sa, halted);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/effect_sequencer.md
Name: effect_sequencer

Overview:
- Program sequencer for the decoration datapath.
- Holds a DEPTH-entry program of 4-bit effect opcodes.
- Steps a program counter through it, decodes each opcode into color/sound/movement actuator controls, and holds each effect for a programmable dwell time.
- Sound is a shared playback channel, so each sound request goes through a valid/ready handshake.
- Sits between the host/config logic and the light, sound and motor drivers.

Parameters:
- DEPTH, 4, number of program entries (power of two, >=2)
- AW, 2, program address width, log2(DEPTH)
- DWELL, 4, cycles each effect is held after issue (>=1)
- CW, 8, dwell counter width (must hold DWELL)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin/resume execution from pc; sampled in IDLE only
- stop  in  1  request halt at end of current opcode; sampled in any non-IDLE state
- prog_we  in  1  program write strobe; honored in IDLE only
- prog_addr  in  AW  program write address
- prog_data  in  4  opcode to write
- snd_valid  out  1  sound request valid
- snd_code  out  2  00 scream, 01 cackle, 10 boo
- snd_ready  in  1  sound channel accepts request
- color  out  2  00 off, 01 green, 10 purple, 11 orange
- wave  out  1  one-cycle pulse, wave hands
- jaw  out  1  one-cycle pulse, move jaw
- fog_on  out  1  fog machine enable, level
- busy  out  1  high in every state except IDLE
- pc  out  AW  current program counter

Behaviour:
- Reset (async):
  - state=IDLE, pc=0, stop_pend=0.
  - color=00, snd_valid=0, snd_code=00, wave=0, jaw=0, fog_on=0, busy=0.
  - Program memory is not cleared.
- Opcode format: [3:2] class, [1:0] sub.
  - 00 system: 00 ON (no-op), 01 RESET, 1x no-op.
  - 01 color: 00 green, 01 purple, 10 orange, 11 off.
  - 10 sound: 00 scream, 01 cackle, 10 boo, 11 no-op.
  - 11 move: 00 wave, 01 jaw, 10 fog, 11 no-op.
- States: IDLE, FETCH, EXEC, WAIT_SND, DWELL.
- IDLE:
  - prog_we writes mem[prog_addr]=prog_data; ignored in all other states.
  - If start=1 -> FETCH.
  - If start and prog_we are both high in the same cycle, the write happens and FETCH still follows.
- FETCH: op <= mem[pc]; -> EXEC. 1 cycle.
- EXEC: 1 cycle, then decode as follows.
  - Color: color register updated; it persists across opcodes until changed, RESET, or rst. -> DWELL.
  - Wave/jaw: the pulse is high for exactly the first DWELL cycle. -> DWELL.
  - Fog: fog_on=1 from the first DWELL cycle; cleared when DWELL exits. -> DWELL.
  - Sound (sub != 11): snd_valid=1, snd_code=sub, both registered. -> WAIT_SND.
  - RESET: pc<=0, color<=00, fog_on<=0, no dwell. -> FETCH, or IDLE if stop_pend.
  - No-op: -> DWELL.
- WAIT_SND:
  - snd_valid and snd_code are held stable until snd_valid & snd_ready.
  - On that cycle snd_valid drops (registered, low next cycle). -> DWELL.
  - No timeout. stop does not abort the handshake.
- DWELL:
  - The counter loads DWELL on entry and decrements each cycle.
  - On the final cycle: pc <= pc+1 (wraps DEPTH-1 -> 0), fog_on <= 0.
  - Then -> FETCH, or -> IDLE with stop_pend cleared if stop_pend.
  - Effect period, non-sound opcode: 2+DWELL cycles from FETCH to next FETCH.
- stop:
  - stop=1 in any non-IDLE state sets stop_pend.
  - Halt takes effect at the next DWELL exit or RESET opcode.
  - pc is preserved, so start resumes at the next opcode.
  - color is retained in IDLE.
- rst mid-operation: immediate return to reset values. An outstanding sound request is dropped (snd_valid=0).
- busy = (state != IDLE).

Test Plan:
- Load mem = {0100, 1000, 1101, 0001} (green, scream, jaw, RESET); snd_ready tied 1; start.
  -> color=01 two cycles after FETCH; snd_valid one cycle with code 00; jaw single-cycle pulse; RESET returns pc=0 with color=00; sequence repeats.
- Sound handshake: op 1010, hold snd_ready=0 for 7 cycles, then 1.
  -> snd_valid=1 and snd_code=10 stable all 7 cycles; DWELL starts the cycle after ready; pc advances after 4 more cycles.
- Fog dwell: program all 1110 with DWELL=4.
  -> fog_on high exactly 4 cycles per opcode, low during FETCH/EXEC; pc cycles 0,1,2,3,0.
- Stop/resume: stop pulsed during the DWELL of entry 1.
  -> IDLE after that dwell with pc=2, busy=0; color held; start -> FETCH of entry 2.
- Write gating: prog_we while busy=1.
  -> memory unchanged. prog_we in IDLE to addr 3 with data 0110, then run -> color=11 on entry 3.
- Async rst asserted in WAIT_SND.
  -> snd_valid, color, fog_on, pc all 0 immediately; state IDLE; start reruns from entry 0.
